// File: rtl/play_sequencer_if.sv
// rtl/play_sequencer_if.sv - song memory read port between play_sequencer and the song RAM
interface play_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 14
);
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_addr, output rd_req, input rd_valid, input rd_data);
   modport slave  (input rd_addr, input rd_req, output rd_valid, output rd_data);
endinterface

// File: rtl/play_sequencer.sv
// rtl/play_sequencer.sv - autonomous song player: fetches {dur, notes, shift} words and times them
// into notes/shift for SoundTop, with rests, pause, stop, loop and end-of-song handling.
module play_sequencer #(
   parameter int NOTE_W   = 8,
   parameter int SHIFT_W  = 2,
   parameter int DUR_W    = 4,
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 25_000_000,
   parameter int GAP_CYC  = 2_500_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               pause_i,
   input  logic               loop_en_i,
   play_sequencer_if.master   rd,
   output logic [NOTE_W-1:0]  notes_out_o,
   output logic [SHIFT_W-1:0] shift_out_o,
   output logic               note_valid_o,
   output logic               busy_o,
   output logic               song_done_o
);
   localparam int DATA_W = DUR_W + NOTE_W + SHIFT_W;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam bit HAS_GAP = (GAP_CYC > 0);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic               rd_req_q, rd_req_d;
   logic [NOTE_W-1:0]  held_notes_q, held_notes_d;
   logic [SHIFT_W-1:0] held_shift_q, held_shift_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [DUR_W-1:0]   beat_q, beat_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               paused_q;
   logic [NOTE_W-1:0]  notes_out_q;
   logic [SHIFT_W-1:0] shift_out_q;
   logic               note_valid_q, busy_q, song_done_q, song_done_d;
   logic               next_note, end_song, sounding_d;

   logic [DUR_W-1:0]   word_dur;
   logic [NOTE_W-1:0]  word_notes;
   logic [SHIFT_W-1:0] word_shift;

   assign word_dur   = rd.rd_data[DATA_W-1 -: DUR_W];
   assign word_notes = rd.rd_data[SHIFT_W +: NOTE_W];
   assign word_shift = rd.rd_data[SHIFT_W-1:0];

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      rd_req_d     = rd_req_q;
      held_notes_d = held_notes_q;
      held_shift_d = held_shift_q;
      tick_d       = tick_q;
      beat_d       = beat_q;
      gap_d        = gap_q;
      song_done_d  = 1'b0;
      next_note    = 1'b0;
      end_song     = 1'b0;

      // paused_q mirrors the cycle in which the outputs are silenced, so held
      // cycles never count towards note or gap length
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_FETCH;
               rd_addr_d = '0;
               rd_req_d  = 1'b1;
            end
         end
         S_FETCH: begin
            if (rd.rd_valid) begin
               rd_req_d = 1'b0;
               if (word_dur != '0) begin
                  state_d      = S_PLAY;
                  held_notes_d = word_notes;
                  held_shift_d = word_shift;
                  beat_d       = word_dur;
                  tick_d       = '0;
               end else begin
                  end_song = 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (!paused_q) begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  beat_d = beat_q - DUR_W'(1);
                  if (beat_q == DUR_W'(1)) begin
                     if (HAS_GAP) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                     end else begin
                        next_note = 1'b1;
                     end
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         S_GAP: begin
            if (!paused_q) begin
               if (gap_q == GAP_LAST) next_note = 1'b1;
               else                   gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // finishing the last address counts as reaching the end of the song
      if (next_note) begin
         if (rd_addr_q == '1) begin
            end_song = 1'b1;
         end else begin
            state_d   = S_FETCH;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_req_d  = 1'b1;
         end
      end

      // an empty song (marker at address 0) never loops
      if (end_song) begin
         if (loop_en_i && (rd_addr_q != '0)) begin
            state_d   = S_FETCH;
            rd_addr_d = '0;
            rd_req_d  = 1'b1;
         end else begin
            state_d     = S_IDLE;
            rd_req_d    = 1'b0;
            song_done_d = 1'b1;
         end
      end

      if (stop_i) begin
         state_d     = S_IDLE;
         rd_req_d    = 1'b0;
         song_done_d = 1'b0;
      end

      sounding_d = (state_d == S_PLAY) && !pause_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rd_addr_q    <= '0;
         rd_req_q     <= 1'b0;
         held_notes_q <= '0;
         held_shift_q <= '0;
         tick_q       <= '0;
         beat_q       <= '0;
         gap_q        <= '0;
         paused_q     <= 1'b0;
         notes_out_q  <= '0;
         shift_out_q  <= '0;
         note_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         song_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         rd_req_q     <= rd_req_d;
         held_notes_q <= held_notes_d;
         held_shift_q <= held_shift_d;
         tick_q       <= tick_d;
         beat_q       <= beat_d;
         gap_q        <= gap_d;
         paused_q     <= pause_i;
         notes_out_q  <= sounding_d ? held_notes_d : '0;
         shift_out_q  <= sounding_d ? held_shift_d : '0;
         note_valid_q <= sounding_d && (held_notes_d != '0);
         busy_q       <= (state_d != S_IDLE);
         song_done_q  <= song_done_d;
      end
   end

   assign rd.rd_addr   = rd_addr_q;
   assign rd.rd_req    = rd_req_q;
   assign notes_out_o  = notes_out_q;
   assign shift_out_o  = shift_out_q;
   assign note_valid_o = note_valid_q;
   assign busy_o       = busy_q;
   assign song_done_o  = song_done_q;
endmodule

// File: tb/tb_play_sequencer.sv
// tb/tb_play_sequencer.sv - directed and randomised songs checked against a per-note timing model
module tb_play_sequencer;
   localparam int NOTE_W = 8, SHIFT_W = 2, DUR_W = 4, ADDR_W = 8;
   localparam int TICK_DIV = 4, GAP_CYC = 2, LAT = 2;
   localparam int DATA_W = DUR_W + NOTE_W + SHIFT_W;
   localparam int NWORDS = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
   logic [NOTE_W-1:0]  notes_out;
   logic [SHIFT_W-1:0] shift_out;
   logic note_valid, busy, song_done;

   play_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rd_if ();

   play_sequencer #(
      .NOTE_W(NOTE_W), .SHIFT_W(SHIFT_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
      .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .pause_i(pause),
      .loop_en_i(loop_en), .rd(rd_if.master), .notes_out_o(notes_out),
      .shift_out_o(shift_out), .note_valid_o(note_valid), .busy_o(busy),
      .song_done_o(song_done)
   );

   always #5 clk = ~clk;

   logic [DUR_W-1:0]   m_dur   [NWORDS];
   logic [NOTE_W-1:0]  m_notes [NWORDS];
   logic [SHIFT_W-1:0] m_shift [NWORDS];
   logic [DATA_W-1:0]  mem     [NWORDS];

   int err_cnt = 0, chk_cnt = 0;
   int mem_cnt = 0, mem_addr = 0;
   int seg_addr[$], seg_sound[$];
   int bad_cnt = 0, done_cnt = 0, busy_cnt = 0;

   initial begin
      rd_if.rd_valid = 1'b0;
      rd_if.rd_data  = '0;
   end

   // memory responder first, then the observer, both on the inactive edge
   always @(negedge clk) begin
      if (rd_if.rd_valid) begin
         rd_if.rd_valid = 1'b0;
      end else if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            rd_if.rd_valid = 1'b1;
            rd_if.rd_data  = mem[mem_addr];
         end
      end else if (rd_if.rd_req) begin
         mem_addr = int'(rd_if.rd_addr);
         mem_cnt  = LAT;
      end

      if (rd_if.rd_valid && rd_if.rd_req) begin
         seg_addr.push_back(int'(rd_if.rd_addr));
         seg_sound.push_back(0);
      end
      if (note_valid) begin
         if (seg_addr.size() == 0) begin
            bad_cnt++;
         end else begin
            seg_sound[seg_sound.size()-1] += 1;
            if (notes_out !== m_notes[seg_addr[seg_addr.size()-1]] ||
                shift_out !== m_shift[seg_addr[seg_addr.size()-1]]) bad_cnt++;
         end
      end
      if (song_done) done_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      seg_addr.delete();
      seg_sound.delete();
      bad_cnt = 0; done_cnt = 0; busy_cnt = 0;
   endtask

   task automatic clear_song();
      for (int i = 0; i < NWORDS; i++) begin
         m_dur[i] = '0; m_notes[i] = '0; m_shift[i] = '0;
      end
   endtask

   task automatic set_word(input int a, input int d, input int n, input int s);
      m_dur[a] = DUR_W'(d); m_notes[a] = NOTE_W'(n); m_shift[a] = SHIFT_W'(s);
   endtask

   task automatic load_mem();
      for (int i = 0; i < NWORDS; i++) mem[i] = {m_dur[i], m_notes[i], m_shift[i]};
   endtask

   task automatic load_t2();
      clear_song();
      set_word(0, 3, 8'h01, 1);
      set_word(1, 1, 8'h80, 0);
      load_mem();
   endtask

   task automatic play_and_wait(input int budget, input bit rand_pause);
      int n;
      clear_mon();
      start = 1'b1;
      step(1);
      start = 1'b0;
      n = 0;
      while (busy && n < budget) begin
         if (rand_pause) pause = ($urandom_range(0, 7) == 0);
         step(1);
         n++;
      end
      pause = 1'b0;
      check("idle_in_budget", int'(busy), 0);
      step(2);
   endtask

   // expected sounding cycles per fetched word come straight from dur*TICK_DIV
   task automatic verify_song(input string tag, input int n_fetch, input int n_done);
      int lim;
      check({tag, "_fetches"}, seg_addr.size(), n_fetch);
      lim = (seg_addr.size() < n_fetch) ? seg_addr.size() : n_fetch;
      for (int i = 0; i < lim; i++) begin
         check({tag, "_addr"}, seg_addr[i], i);
         check({tag, "_sound"}, seg_sound[i],
               (m_notes[i] != '0) ? int'(m_dur[i]) * TICK_DIV : 0);
      end
      check({tag, "_note_value"}, bad_cnt, 0);
      check({tag, "_song_done"}, done_cnt, n_done);
   endtask

   task automatic wait_note(input int budget);
      int n = 0;
      while (!note_valid && n < budget) begin
         step(1);
         n++;
      end
      check("note_seen", int'(note_valid), 1);
   endtask

   initial begin
      int L, n;
      clear_song();
      load_mem();
      step(3);
      check("reset_outs", int'({notes_out, shift_out, note_valid, busy, song_done,
                                rd_if.rd_req, rd_if.rd_addr}), 0);
      rst = 1'b0;
      step(2);

      // T1: reset mid-play, then reset with a read outstanding
      load_t2();
      clear_mon();
      start = 1'b1; step(1); start = 1'b0;
      check("t1_fetch_req", int'({busy, rd_if.rd_req}), 3);
      wait_note(20);
      step(3);
      rst = 1'b1; step(1);
      check("t1_rst_outs", int'({notes_out, shift_out, note_valid, busy, song_done,
                                 rd_if.rd_req, rd_if.rd_addr}), 0);
      step(2); rst = 1'b0; step(1);
      check("t1_idle_after", int'(busy), 0);
      start = 1'b1; step(1); start = 1'b0;
      rst = 1'b1; step(1); rst = 1'b0;
      step(6);
      check("t1_late_valid_ignored", int'({busy, note_valid, rd_if.rd_req}), 0);

      // T2: basic song, exact length and single done pulse
      load_t2();
      play_and_wait(200, 1'b0);
      verify_song("t2", 3, 1);
      check("t2_busy_cycles", busy_cnt, 3 + 12 + 2 + 3 + 4 + 2 + 3);

      // T4: pause for 5 cycles at the 6th sounding cycle of the first note
      clear_mon();
      start = 1'b1; step(1); start = 1'b0;
      wait_note(20);
      step(5);
      pause = 1'b1; step(1);
      check("t4_paused_silent", int'({notes_out, note_valid}), 0);
      step(4); pause = 1'b0; step(1);
      check("t4_resumed", int'(notes_out), 8'h01);
      n = 0;
      while (busy && n < 200) begin step(1); n++; end
      step(2);
      verify_song("t4", 3, 1);
      check("t4_busy_cycles", busy_cnt, 29 + 5);

      // T3: loop replays from address 0; empty song with loop still ends
      loop_en = 1'b1;
      clear_mon();
      start = 1'b1; step(1); start = 1'b0;
      n = 0;
      while (!(seg_sound.size() >= 4 && seg_sound[3] > 0) && n < 200) begin step(1); n++; end
      check("t3_refetches", (seg_addr.size() >= 4) ? 1 : 0, 1);
      if (seg_addr.size() >= 4) check("t3_loop_addr", seg_addr[3], 0);
      check("t3_no_done", done_cnt, 0);
      check("t3_replay_note", int'(notes_out), 8'h01);
      stop = 1'b1; step(1); stop = 1'b0;
      check("t3_stop_idle", int'({busy, note_valid, rd_if.rd_req}), 0);
      step(3);
      check("t3_stop_no_done", done_cnt, 0);
      clear_song();
      load_mem();
      play_and_wait(100, 1'b0);
      verify_song("t3_empty", 1, 1);
      loop_en = 1'b0;

      // T5: rest is timed like a note but stays silent
      clear_song();
      set_word(0, 2, 8'h00, 0);
      set_word(1, 1, 8'h04, 2);
      load_mem();
      play_and_wait(200, 1'b0);
      verify_song("t5", 3, 1);
      check("t5_busy_cycles", busy_cnt, 3 + 8 + 2 + 3 + 4 + 2 + 3);

      // T6: stop and start together during fetch
      load_t2();
      clear_mon();
      start = 1'b1; step(1);
      stop = 1'b1; step(1);
      check("t6_stop_idle", int'({busy, rd_if.rd_req, note_valid}), 0);
      start = 1'b0; stop = 1'b0;
      step(6);
      check("t6_stays_idle", int'(busy), 0);
      check("t6_no_done", done_cnt, 0);
      check("t6_no_fetch", seg_addr.size(), 0);

      // randomised songs with random pausing
      for (int it = 0; it < 6; it++) begin
         clear_song();
         L = $urandom_range(1, 6);
         for (int i = 0; i < L; i++)
            set_word(i, $urandom_range(1, 4),
                     ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                     $urandom_range(0, 3));
         load_mem();
         play_and_wait(1000, 1'b1);
         verify_song("rand", L + 1, 1);
      end

      // address wrap: a full memory ends after the last address without refetching 0
      clear_song();
      for (int i = 0; i < NWORDS; i++) set_word(i, 1, (i + 1) & 8'hff, i & 3);
      load_mem();
      play_and_wait(3000, 1'b0);
      verify_song("wrap", NWORDS, 1);
      check("wrap_busy_cycles", busy_cnt, NWORDS * (3 + TICK_DIV + GAP_CYC));

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
